// File: rtl/enc_home_pkg.sv
// ============================================================================
// enc_home_pkg : shared types and defaults for the encoder homing controller
// Rev 1.0
// ============================================================================
`default_nettype none

package enc_home_pkg;

  localparam int CPR_DEF     = 32768;
  localparam int CPR_TOL_DEF = 4;
  localparam int TIMEOUT_DEF = 50_000_000;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CLEAR    = 4'd1,
    ST_WAIT_RDY = 4'd2,
    ST_ARM1     = 4'd3,
    ST_WAIT_Z1  = 4'd4,
    ST_ARM2     = 4'd5,
    ST_WAIT_Z2  = 4'd6,
    ST_CHECK    = 4'd7,
    ST_DONE     = 4'd8,
    ST_FAIL     = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_READY_TO     = 3'd1,
    FC_INDEX_TO     = 3'd2,
    FC_ENC_ERR      = 3'd3,
    FC_CPR_MISMATCH = 3'd4,
    FC_ABORT        = 3'd5
  } fail_code_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enc_home_ctrl_wd_timer.sv
// ============================================================================
// wd_timer : loadable down-counter watchdog; expired while the count is zero
// Rev 1.0
// ============================================================================
`default_nettype none

module wd_timer #(
  parameter int TIMEOUT = 50_000_000
) (
  input  logic clock,
  input  logic aclr_n,
  input  logic reload,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  // Loaded with TIMEOUT-1 so expiry is seen on the TIMEOUT-th cycle after reload
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= W'(TIMEOUT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/enc_home_ctrl.sv
// ============================================================================
// enc_home_ctrl : encoder homing sequencer (clear, ready, two index captures,
//                 revolution-length check). Rev 1.0
// ============================================================================
`default_nettype none

module enc_home_ctrl
  import enc_home_pkg::*;
#(
  parameter int CPR     = CPR_DEF,
  parameter int CPR_TOL = CPR_TOL_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               aclr_n,
  input  logic               start,
  input  logic               abort,
  input  logic               dir_req,
  output logic               enc_sclr,
  output logic               enc_Z_clr,
  output logic               enc_ena,
  output logic               enc_dir,
  input  logic               enc_ready,
  input  logic               enc_error,
  input  logic               enc_Z_flag,
  input  logic signed [31:0] enc_counter,
  input  logic signed [31:0] enc_Z_pos,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [2:0]         fail_code,
  output logic signed [31:0] home_pos,
  output logic signed [31:0] rev_counts,
  output logic signed [31:0] position
);

  state_t      state, state_nx;
  logic [2:0]  fc_nx;
  logic        accept, cap_home, cap_rev;
  logic        tmr_reload, tmr_expired;
  logic [31:0] rev_nx, dev;

  wd_timer #(.TIMEOUT(TIMEOUT)) u_wd (
    .clock   (clock),
    .aclr_n  (aclr_n),
    .reload  (tmr_reload),
    .expired (tmr_expired)
  );

  always_comb begin
    state_nx = state;
    fc_nx    = fail_code;
    accept   = 1'b0;
    cap_home = 1'b0;
    cap_rev  = 1'b0;
    rev_nx   = abs32(enc_Z_pos - home_pos);
    dev      = abs32(rev_counts - 32'(CPR));
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_nx = ST_CLEAR;
          fc_nx    = FC_NONE;
          accept   = 1'b1;
        end
      end
      default: begin
        // Priority: abort, then encoder error, then normal progress/timeout
        if (abort) begin
          state_nx = ST_FAIL;
          fc_nx    = FC_ABORT;
        end else if (enc_error && state != ST_CLEAR && state != ST_WAIT_RDY) begin
          state_nx = ST_FAIL;
          fc_nx    = FC_ENC_ERR;
        end else begin
          case (state)
            ST_CLEAR: state_nx = ST_WAIT_RDY;
            ST_WAIT_RDY: begin
              if (enc_ready) begin
                state_nx = ST_ARM1;
              end else if (tmr_expired) begin
                state_nx = ST_FAIL;
                fc_nx    = FC_READY_TO;
              end
            end
            ST_ARM1: state_nx = ST_WAIT_Z1;
            ST_WAIT_Z1: begin
              if (enc_Z_flag) begin
                state_nx = ST_ARM2;
                cap_home = 1'b1;
              end else if (tmr_expired) begin
                state_nx = ST_FAIL;
                fc_nx    = FC_INDEX_TO;
              end
            end
            ST_ARM2: state_nx = ST_WAIT_Z2;
            ST_WAIT_Z2: begin
              if (enc_Z_flag) begin
                state_nx = ST_CHECK;
                cap_rev  = 1'b1;
              end else if (tmr_expired) begin
                state_nx = ST_FAIL;
                fc_nx    = FC_INDEX_TO;
              end
            end
            ST_CHECK: begin
              if (dev <= 32'(CPR_TOL)) begin
                state_nx = ST_DONE;
              end else begin
                state_nx = ST_FAIL;
                fc_nx    = FC_CPR_MISMATCH;
              end
            end
            default: state_nx = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  assign tmr_reload = (state_nx != state) &&
                      (state_nx == ST_WAIT_RDY || state_nx == ST_WAIT_Z1 ||
                       state_nx == ST_WAIT_Z2);

  // Status outputs are decoded from the next state so they align with state
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      enc_sclr   <= 1'b0;
      enc_Z_clr  <= 1'b0;
      enc_ena    <= 1'b0;
      enc_dir    <= 1'b0;
      fail_code  <= FC_NONE;
      home_pos   <= '0;
      rev_counts <= '0;
      position   <= '0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx inside {ST_CLEAR, ST_WAIT_RDY, ST_ARM1, ST_WAIT_Z1,
                                     ST_ARM2, ST_WAIT_Z2, ST_CHECK});
      enc_ena   <= (state_nx inside {ST_WAIT_RDY, ST_ARM1, ST_WAIT_Z1, ST_ARM2,
                                     ST_WAIT_Z2, ST_CHECK, ST_DONE});
      enc_sclr  <= (state_nx == ST_CLEAR);
      enc_Z_clr <= (state_nx == ST_ARM1) || (state_nx == ST_ARM2);
      done      <= (state_nx == ST_DONE);
      fail      <= (state_nx == ST_FAIL);
      fail_code <= fc_nx;
      if (accept) begin
        enc_dir <= dir_req;
      end
      if (cap_home) begin
        home_pos <= enc_Z_pos;
      end
      if (cap_rev) begin
        rev_counts <= rev_nx;
      end
      position <= (state == ST_DONE) ? (enc_counter - home_pos) : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_enc_home_ctrl.sv
// ============================================================================
// tb_enc_home_ctrl : scoreboard bench with a behavioural encoder model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_enc_home_ctrl;

  logic               clock = 1'b0;
  logic               aclr_n;
  logic               start, abort, dir_req;
  logic               enc_sclr, enc_Z_clr, enc_ena, enc_dir;
  logic               enc_ready, enc_error, enc_Z_flag;
  logic signed [31:0] enc_counter, enc_Z_pos;
  logic               busy, done, fail;
  logic [2:0]         fail_code;
  logic signed [31:0] home_pos, rev_counts, position;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit                 is_done;
    logic [2:0]         code;
    logic signed [31:0] home;
    logic signed [31:0] rev;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  bit   pd = 1'b0, pf = 1'b0;
  int   sclr_cnt = 0;

  // Encoder model request interface
  bit                 z_req = 1'b0;
  bit                 z_err = 1'b0;
  logic signed [31:0] z_val = '0;
  int                 rdy_cnt;

  always #5 clock = ~clock;

  enc_home_ctrl #(.CPR(32768), .CPR_TOL(4), .TIMEOUT(1000)) dut (
    .clock       (clock),
    .aclr_n      (aclr_n),
    .start       (start),
    .abort       (abort),
    .dir_req     (dir_req),
    .enc_sclr    (enc_sclr),
    .enc_Z_clr   (enc_Z_clr),
    .enc_ena     (enc_ena),
    .enc_dir     (enc_dir),
    .enc_ready   (enc_ready),
    .enc_error   (enc_error),
    .enc_Z_flag  (enc_Z_flag),
    .enc_counter (enc_counter),
    .enc_Z_pos   (enc_Z_pos),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .fail_code   (fail_code),
    .home_pos    (home_pos),
    .rev_counts  (rev_counts),
    .position    (position)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return enc_Z_clr;
      1:       return enc_sclr;
      2:       return done || fail;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (cond(which)) return;
      @(negedge clock);
    end
    if (!cond(which)) begin
      checks++;
      errors++;
      $display("FAIL %s: timed out after %0d cycles", name, budget);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_start(input bit d);
    @(negedge clock);
    start   = 1'b1;
    dir_req = d;
    @(negedge clock);
    start   = 1'b0;
  endtask

  task automatic inject(input logic signed [31:0] v, input bit err);
    z_val = v;
    z_err = err;
    z_req = 1'b1;
  endtask

  task automatic push(input bit d, input logic [2:0] c, input int h, input int r);
    exp_t x;
    x.is_done = d;
    x.code    = c;
    x.home    = h;
    x.rev     = r;
    sb.push_back(x);
  endtask

  task automatic run_seq(input bit d, input int z1, input int z2, input bit err2);
    do_start(d);
    wait_for(0, 400, "arm1_wait");
    tick(20);
    inject(z1, 1'b0);
    wait_for(0, 100, "arm2_wait");
    tick(20);
    inject(z2, err2);
    wait_for(2, 50, "result_wait");
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_busy"},      busy,       0);
    chk({p, "_done"},      done,       0);
    chk({p, "_fail"},      fail,       0);
    chk({p, "_fail_code"}, fail_code,  0);
    chk({p, "_sclr"},      enc_sclr,   0);
    chk({p, "_zclr"},      enc_Z_clr,  0);
    chk({p, "_ena"},       enc_ena,    0);
    chk({p, "_dir"},       enc_dir,    0);
    chk({p, "_home"},      home_pos,   0);
    chk({p, "_rev"},       rev_counts, 0);
    chk({p, "_position"},  position,   0);
  endtask

  // Encoder model: counter, ready after 200 enabled cycles, index flag capture
  initial begin
    enc_ready   = 1'b0;
    enc_error   = 1'b0;
    enc_Z_flag  = 1'b0;
    enc_counter = '0;
    enc_Z_pos   = '0;
    rdy_cnt     = 0;
    forever begin
      @(posedge clock);
      #1;
      if (enc_sclr) begin
        enc_counter = '0;
        rdy_cnt     = 0;
        enc_ready   = 1'b0;
      end else if (enc_ena) begin
        enc_counter = enc_dir ? enc_counter + 1 : enc_counter - 1;
        if (rdy_cnt < 200) rdy_cnt++;
        enc_ready = (rdy_cnt >= 200);
      end
      if (enc_Z_clr) enc_Z_flag = 1'b0;
      enc_error = 1'b0;
      if (z_req) begin
        enc_Z_flag = 1'b1;
        enc_Z_pos  = z_val;
        enc_error  = z_err;
        z_req      = 1'b0;
        z_err      = 1'b0;
      end
    end
  end

  // Monitor: compares each new done/fail result against the scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if ((done && !pd) || (fail && !pf)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got done=%0d fail=%0d code=%0d, no result expected",
                   done, fail, fail_code);
        end else begin
          e = sb.pop_front();
          chk("sb_done",      done,       e.is_done);
          chk("sb_fail",      fail,       !e.is_done);
          chk("sb_fail_code", fail_code,  e.code);
          chk("sb_home_pos",  home_pos,   e.home);
          chk("sb_rev_counts", rev_counts, e.rev);
        end
      end
      if (enc_sclr) sclr_cnt++;
      pd = done;
      pf = fail;
    end
  end

  initial begin
    logic signed [31:0] c;
    int n;
    aclr_n  = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    dir_req = 1'b0;
    tick(3);
    #1;
    check_reset_vals("rst");
    @(negedge clock);
    aclr_n = 1'b1;
    tick(3);

    // Nominal homing run
    push(1'b1, 3'd0, 1000, 32768);
    run_seq(1'b0, 1000, 1000 + 32768, 1'b0);
    chk("nom_enc_dir", enc_dir, 0);
    chk("nom_busy", busy, 0);
    c = enc_counter;
    tick(1);
    chk("nom_position", position, c - 32'sd1000);

    // Revolution length outside tolerance
    push(1'b0, 3'd4, 1000, 32780);
    run_seq(1'b0, 1000, 1000 + 32780, 1'b0);

    // No index: timeout measured from the ARM1 pulse (WAIT_Z1 entry is one later)
    push(1'b0, 3'd2, 1000, 32780);
    do_start(1'b0);
    wait_for(0, 400, "to_arm1_wait");
    n = 0;
    for (int i = 0; i < 1200 && !fail; i++) begin
      @(negedge clock);
      n++;
    end
    chk("to_cycles_after_arm1", n, 1001);

    // Encoder error coincident with second index
    push(1'b0, 3'd3, 2000, 32780);
    run_seq(1'b0, 2000, 2000 + 32768, 1'b1);

    // Abort in WAIT_RDY, then a clean run with dir_req=1
    push(1'b0, 3'd5, 2000, 32780);
    do_start(1'b0);
    tick(5);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_fail_next_cycle", fail, 1);
    chk("abort_code", fail_code, 5);
    tick(2);
    sclr_cnt = 0;
    push(1'b1, 3'd0, 1000, 32768);
    run_seq(1'b1, 1000, 1000 + 32768, 1'b0);
    chk("dir1_enc_dir", enc_dir, 1);
    chk("dir1_sclr_pulses", sclr_cnt, 1);

    // Reset in WAIT_Z1
    do_start(1'b0);
    wait_for(0, 400, "rst_arm1_wait");
    tick(10);
    aclr_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clock);
    aclr_n = 1'b1;
    tick(5);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_fail", fail, 0);
    chk("post_rst_ena", enc_ena, 0);

    chk("sb_leftover", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
